// File: rtl/muldiv_execute.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_execute
// Description : Iterative RV32M multiply/divide unit that stalls execute while it runs.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_execute #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_e_i,
    input  logic [2:0]       funct3_e_i,
    input  logic [WIDTH-1:0] src_a_e_i,
    input  logic [WIDTH-1:0] src_b_e_i,
    input  logic [4:0]       rd_e_i,
    input  logic             reg_write_e_i,
    input  logic             flush_e_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o,
    output logic             reg_write_o
);

    localparam logic [1:0]       c_state_idle = 2'd0;
    localparam logic [1:0]       c_state_calc = 2'd1;
    localparam logic [1:0]       c_state_done = 2'd2;
    localparam logic [5:0]       c_last_iter  = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_min_int    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [2:0]         r_funct3;
    logic [4:0]         r_rd;
    logic               r_reg_write;
    logic               r_neg;
    logic [5:0]         r_cnt;
    logic [WIDTH-1:0]   r_opd;
    logic [2*WIDTH-1:0] r_acc;

    // Operand decode at issue
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_res_neg;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic [WIDTH-1:0] w_special_res;

    always_comb begin
        w_is_div   = funct3_e_i[2];
        w_a_signed = (funct3_e_i == 3'b000) || (funct3_e_i == 3'b001) || (funct3_e_i == 3'b010) ||
                     (funct3_e_i == 3'b100) || (funct3_e_i == 3'b110);
        w_b_signed = (funct3_e_i == 3'b000) || (funct3_e_i == 3'b001) ||
                     (funct3_e_i == 3'b100) || (funct3_e_i == 3'b110);
        w_a_neg    = w_a_signed & src_a_e_i[WIDTH-1];
        w_b_neg    = w_b_signed & src_b_e_i[WIDTH-1];
        w_a_mag    = w_a_neg ? -src_a_e_i : src_a_e_i;
        w_b_mag    = w_b_neg ? -src_b_e_i : src_b_e_i;
        // Remainder follows the dividend; everything else takes the XOR of signs
        w_res_neg  = (w_is_div && funct3_e_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = w_is_div && (src_b_e_i == '0);
        w_div_ovf  = w_is_div && !funct3_e_i[0] && (src_a_e_i == c_min_int) && (src_b_e_i == '1);
        if (w_div_zero) begin
            w_special_res = funct3_e_i[1] ? src_a_e_i : '1;
        end else begin
            w_special_res = funct3_e_i[1] ? '0 : c_min_int;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH-1:0]   w_div_sel;
    logic [WIDTH-1:0]   w_final;

    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
        w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_rem_diff  = w_rem_shift - {1'b0, r_opd};
        w_q_bit     = ~w_rem_diff[WIDTH];
        if (r_funct3[2]) begin
            w_acc_next = {(w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_q_bit};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
        w_prod_signed = r_neg ? -w_acc_next : w_acc_next;
        w_div_sel     = r_funct3[1] ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
        if (r_funct3[2]) begin
            w_final = r_neg ? -w_div_sel : w_div_sel;
        end else if (r_funct3[1:0] == 2'b00) begin
            w_final = w_prod_signed[WIDTH-1:0];
        end else begin
            w_final = w_prod_signed[2*WIDTH-1:WIDTH];
        end
    end

    // The stall must take effect in the issue cycle, so it is not registered
    always_comb begin
        busy_o = ((r_state == c_state_idle) && start_e_i && !flush_e_i) ||
                 (r_state == c_state_calc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_state_idle;
            r_funct3    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_opd       <= '0;
            r_acc       <= '0;
            done_o      <= 1'b0;
            result_o    <= '0;
            rd_o        <= '0;
            reg_write_o <= 1'b0;
        end else begin
            done_o      <= 1'b0;
            reg_write_o <= 1'b0;
            if (flush_e_i) begin
                r_state <= c_state_idle;
            end else begin
                case (r_state)
                    c_state_idle: begin
                        if (start_e_i) begin
                            r_funct3    <= funct3_e_i;
                            r_rd        <= rd_e_i;
                            r_reg_write <= reg_write_e_i;
                            r_neg       <= w_res_neg;
                            r_cnt       <= '0;
                            r_opd       <= w_is_div ? w_b_mag : w_a_mag;
                            r_acc       <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                            if (w_div_zero || w_div_ovf) begin
                                result_o    <= w_special_res;
                                rd_o        <= rd_e_i;
                                reg_write_o <= reg_write_e_i;
                                done_o      <= 1'b1;
                                r_state     <= c_state_done;
                            end else begin
                                r_state <= c_state_calc;
                            end
                        end
                    end
                    c_state_calc: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_last_iter) begin
                            result_o    <= w_final;
                            rd_o        <= r_rd;
                            reg_write_o <= r_reg_write;
                            done_o      <= 1'b1;
                            r_state     <= c_state_done;
                        end
                    end
                    // start is still the same stalled instruction here
                    c_state_done: r_state <= c_state_idle;
                    default:      r_state <= c_state_idle;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_execute.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_execute
// Description : Scoreboard bench for the iterative RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_e_i;
    logic [2:0]  funct3_e_i;
    logic [31:0] src_a_e_i;
    logic [31:0] src_b_e_i;
    logic [4:0]  rd_e_i;
    logic        reg_write_e_i;
    logic        flush_e_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        reg_write_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    muldiv_execute #(.WIDTH(32)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start_e_i     (start_e_i),
        .funct3_e_i    (funct3_e_i),
        .src_a_e_i     (src_a_e_i),
        .src_b_e_i     (src_b_e_i),
        .rd_e_i        (rd_e_i),
        .reg_write_e_i (reg_write_e_i),
        .flush_e_i     (flush_e_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .result_o      (result_o),
        .rd_o          (rd_o),
        .reg_write_o   (reg_write_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0]        ae, be, p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin ae = {{32{a[31]}}, a}; be = {{32{b[31]}}, b}; p = ae * be; return p[63:32]; end
            3'd2: begin ae = {{32{a[31]}}, a}; be = {32'b0, b}; p = ae * be; return p[63:32]; end
            3'd3: begin ae = {32'b0, a}; be = {32'b0, b}; p = ae * be; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Output side of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done_o) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", result_o, e.res);
                check("rd", 32'(rd_o), 32'(e.rd));
                check("reg_write", 32'(reg_write_o), 32'(e.rw));
            end
        end
    end

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw, input bit hold,
                         input logic [31:0] exp_res);
        exp_t e;
        int   lat, cyc, busy_cnt;
        e.res = exp_res;
        e.rd  = rd;
        e.rw  = rw;
        lat = (f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
        @(negedge clk);
        start_e_i     = 1'b1;
        funct3_e_i    = f3;
        src_a_e_i     = a;
        src_b_e_i     = b;
        rd_e_i        = rd;
        reg_write_e_i = rw;
        #1;
        check("busy_issue", 32'(busy_o), 32'd1);
        sb_q.push_back(e);
        cyc      = 0;
        busy_cnt = 1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done_o) break;
            if (cyc == 1) check("rw_in_calc", 32'(reg_write_o), 32'd0);
            if (busy_o) busy_cnt++;
            if (!hold) start_e_i = 1'b0;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("busy_cycles", 32'(busy_cnt), 32'(lat));
        check("busy_in_done", 32'(busy_o), 32'd0);
        if (hold) begin
            @(negedge clk);
            check("no_reissue", 32'(done_o), 32'd0);
        end
        start_e_i = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        rst = 1'b1;
        start_e_i = 1'b0;
        funct3_e_i = '0;
        src_a_e_i = '0;
        src_b_e_i = '0;
        rd_e_i = '0;
        reg_write_e_i = 1'b0;
        flush_e_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_rw", 32'(reg_write_o), 32'd0);
        rst = 1'b0;

        do_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 1'b1, 1'b0, 32'hFFFF_FFEB);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0, 32'hFFFF_FFFE);
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1, 1'b0, 32'h0000_0000);
        do_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 1'b1, 1'b0, 32'hFFFF_FFFF);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 1'b0, 32'hFFFF_FFFD);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 1'b0, 32'hFFFF_FFFF);
        do_op(3'b101, 32'd100, 32'd7, 5'd7, 1'b0, 1'b0, 32'd14);
        do_op(3'b111, 32'd100, 32'd7, 5'd8, 1'b1, 1'b0, 32'd2);
        do_op(3'b100, 32'h0000_0055, 32'd0, 5'd10, 1'b1, 1'b0, 32'hFFFF_FFFF);
        do_op(3'b111, 32'h0000_1234, 32'd0, 5'd11, 1'b1, 1'b0, 32'h0000_1234);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 1'b0, 32'h8000_0000);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 1'b0, 32'h0000_0000);

        // Flush in cycle 10 of a DIVU: nothing may come out of it
        @(negedge clk);
        start_e_i = 1'b1; funct3_e_i = 3'b101; src_a_e_i = 32'd1000; src_b_e_i = 32'd3;
        rd_e_i = 5'd9; reg_write_e_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_e_i = 1'b0;
        end
        flush_e_i = 1'b1;
        @(negedge clk);
        flush_e_i = 1'b0;
        #1;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_done", 32'(done_o), 32'd0);
        repeat (40) @(negedge clk);
        do_op(3'b101, 32'd100, 32'd7, 5'd12, 1'b1, 1'b0, 32'd14);

        // Reset in the middle of a multiply clears every output
        @(negedge clk);
        start_e_i = 1'b1; funct3_e_i = 3'b000; src_a_e_i = 32'd5; src_b_e_i = 32'd6;
        rd_e_i = 5'd15; reg_write_e_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start_e_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_result", result_o, 32'd0);
        check("midrst_rd", 32'(rd_o), 32'd0);
        check("midrst_rw", 32'(reg_write_o), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        do_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd20, 1'b1, 1'b1, 32'hFFFF_FFEB);
        do_op(3'b101, 32'hDEAD_BEEF, 32'd0, 5'd21, 1'b1, 1'b1, 32'hFFFF_FFFF);

        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'd0 : $urandom;
            do_op(f3, a, b, 5'(i + 16), 1'b1, 1'b0, ref_model(f3, a, b));
        end

        repeat (40) @(negedge clk);
        check("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
